// File: rtl/timer_counter_mc_if.sv
// Bus bundle for the multi-channel timer counter: control inputs, packed
// per-channel tdr/cmp values, counter outputs and the interrupt request.
interface timer_counter_mc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PSC_W = 8
);
  logic [PSC_W-1:0]     psc;
  logic [NCH-1:0]       load;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       updown;
  logic [NCH-1:0]       auto_reload;
  logic [NCH-1:0]       int_clr;
  logic [NCH*WIDTH-1:0] tdr;
  logic [NCH*WIDTH-1:0] cmp;
  logic [NCH*WIDTH-1:0] cnt;
  logic [NCH*WIDTH-1:0] last_cnt;
  logic [NCH-1:0]       ovf_flag;
  logic [NCH-1:0]       cmp_flag;
  logic [NCH-1:0]       done;
  logic                 irq;

  modport master (
    output psc, load, en, updown, auto_reload, int_clr, tdr, cmp,
    input  cnt, last_cnt, ovf_flag, cmp_flag, done, irq
  );

  modport slave (
    input  psc, load, en, updown, auto_reload, int_clr, tdr, cmp,
    output cnt, last_cnt, ovf_flag, cmp_flag, done, irq
  );
endinterface

// File: rtl/timer_counter_mc.sv
// NCH independent up/down counters sharing one prescaler tick, each with
// one-shot/periodic wrap handling, sticky wrap/compare flags and an ORed irq.
module timer_counter_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PSC_W = 8
) (
  input  logic         pclk,
  input  logic         preset_n,
  timer_counter_mc_if.slave bus
);

  typedef enum logic {RUN, DONE} state_e;

  logic [PSC_W-1:0]     psc_cnt_q, psc_cnt_d;
  logic                 tick;
  logic [NCH*WIDTH-1:0] cnt_q, cnt_d;
  logic [NCH*WIDTH-1:0] last_cnt_q, last_cnt_d;
  logic [NCH-1:0]       ovf_flag_q, ovf_flag_d;
  logic [NCH-1:0]       cmp_flag_q, cmp_flag_d;
  state_e               state_q [NCH];
  state_e               state_d [NCH];

  // Comparing with >= lets a lowered psc take effect on the very next cycle.
  always_comb begin
    tick      = (psc_cnt_q >= bus.psc);
    psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
  end

  always_comb begin : chan_next
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] nxt;
    cur        = '0;
    term       = '0;
    nxt        = '0;
    cnt_d      = cnt_q;
    last_cnt_d = cnt_q;
    // Clear is applied first so a same-cycle set below overrides it.
    ovf_flag_d = ovf_flag_q & ~bus.int_clr;
    cmp_flag_d = cmp_flag_q & ~bus.int_clr;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cur        = cnt_q[i*WIDTH +: WIDTH];
      term       = bus.updown[i] ? '0 : '1;
      nxt        = cur;
      if (bus.load[i]) begin
        nxt        = bus.tdr[i*WIDTH +: WIDTH];
        state_d[i] = RUN;
      end else if (bus.en[i] && tick && (state_q[i] == RUN)) begin
        if (cur == term) begin
          ovf_flag_d[i] = 1'b1;
          if (bus.auto_reload[i]) nxt = bus.tdr[i*WIDTH +: WIDTH];
          else                    state_d[i] = DONE;
        end else if (bus.updown[i]) begin
          nxt = cur - 1'b1;
        end else begin
          nxt = cur + 1'b1;
        end
        if (nxt == bus.cmp[i*WIDTH +: WIDTH]) cmp_flag_d[i] = 1'b1;
      end
      cnt_d[i*WIDTH +: WIDTH] = nxt;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psc_cnt_q  <= '0;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      ovf_flag_q <= '0;
      cmp_flag_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) state_q[i] <= RUN;
    end else begin
      psc_cnt_q  <= psc_cnt_d;
      cnt_q      <= cnt_d;
      last_cnt_q <= last_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      cmp_flag_q <= cmp_flag_d;
      for (int unsigned i = 0; i < NCH; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    bus.done = '0;
    for (int unsigned i = 0; i < NCH; i++) bus.done[i] = (state_q[i] == DONE);
  end

  assign bus.cnt      = cnt_q;
  assign bus.last_cnt = last_cnt_q;
  assign bus.ovf_flag = ovf_flag_q;
  assign bus.cmp_flag = cmp_flag_q;
  assign bus.irq      = |(ovf_flag_q | cmp_flag_q);

endmodule

// File: tb/tb_timer_counter_mc.sv
// Directed bench for timer_counter_mc (WIDTH=8, NCH=4): hand-computed
// expectations per scenario, sampled 1 ns after each rising edge.
module tb_timer_counter_mc;
  localparam int W = 8;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  timer_counter_mc_if #(.WIDTH(8), .NCH(4), .PSC_W(8)) bus ();

  timer_counter_mc #(.WIDTH(8), .NCH(4), .PSC_W(8)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    bus.psc = '0; bus.load = '0; bus.en = '0; bus.updown = '0;
    bus.auto_reload = '0; bus.int_clr = '0; bus.tdr = '0; bus.cmp = '0;
    tick(2);
    checks++; if (bus.cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h expected %h", bus.cnt, 32'h0); end
    checks++; if (bus.last_cnt !== 32'h0) begin errors++; $display("FAIL reset_last_cnt: got %h expected %h", bus.last_cnt, 32'h0); end
    checks++; if ({bus.ovf_flag, bus.cmp_flag, bus.done, bus.irq} !== 13'h0) begin errors++; $display("FAIL reset_flags: got %h expected %h", {bus.ovf_flag, bus.cmp_flag, bus.done, bus.irq}, 13'h0); end
    preset_n = 1'b1;
  endtask

  task automatic test_up_periodic;
    logic [7:0] seq [3];
    seq = '{8'hFD, 8'hFE, 8'hFF};
    bus.tdr[0*W +: W] = 8'hFC; bus.cmp[0*W +: W] = 8'h55;
    bus.updown[0] = 1'b0; bus.auto_reload[0] = 1'b1; bus.load[0] = 1'b1;
    tick(1);
    checks++; if (bus.cnt[0*W +: W] !== 8'hFC) begin errors++; $display("FAIL up_load: got %h expected %h", bus.cnt[0*W +: W], 8'hFC); end
    bus.load[0] = 1'b0; bus.en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++; if (bus.cnt[0*W +: W] !== seq[k]) begin errors++; $display("FAIL up_step%0d: got %h expected %h", k, bus.cnt[0*W +: W], seq[k]); end
    end
    checks++; if (bus.ovf_flag[0] !== 1'b0) begin errors++; $display("FAIL up_no_ovf_early: got %b expected 0", bus.ovf_flag[0]); end
    tick(1);
    checks++; if (bus.cnt[0*W +: W] !== 8'hFC) begin errors++; $display("FAIL up_reload: got %h expected %h", bus.cnt[0*W +: W], 8'hFC); end
    checks++; if (bus.last_cnt[0*W +: W] !== 8'hFF) begin errors++; $display("FAIL up_last_cnt: got %h expected %h", bus.last_cnt[0*W +: W], 8'hFF); end
    checks++; if ({bus.ovf_flag[0], bus.irq, bus.cmp_flag[0]} !== 3'b110) begin errors++; $display("FAIL up_wrap_flags: got %b expected 110", {bus.ovf_flag[0], bus.irq, bus.cmp_flag[0]}); end
    bus.en[0] = 1'b0; bus.int_clr[0] = 1'b1;
    tick(1);
    bus.int_clr[0] = 1'b0;
    checks++; if ({bus.ovf_flag[0], bus.irq} !== 2'b00) begin errors++; $display("FAIL up_int_clr: got %b expected 00", {bus.ovf_flag[0], bus.irq}); end
    checks++; if (bus.cnt[0*W +: W] !== 8'hFC) begin errors++; $display("FAIL up_hold_disabled: got %h expected %h", bus.cnt[0*W +: W], 8'hFC); end
  endtask

  task automatic test_down_oneshot;
    preset_n = 1'b0; bus.psc = 8'd3;
    tick(1);
    preset_n = 1'b1;
    bus.tdr[1*W +: W] = 8'h02; bus.cmp[1*W +: W] = 8'hAA;
    bus.updown[1] = 1'b1; bus.auto_reload[1] = 1'b0; bus.load[1] = 1'b1;
    tick(1);
    checks++; if (bus.cnt[1*W +: W] !== 8'h02) begin errors++; $display("FAIL dn_load: got %h expected %h", bus.cnt[1*W +: W], 8'h02); end
    bus.load[1] = 1'b0; bus.en[1] = 1'b1;
    tick(2);
    checks++; if (bus.cnt[1*W +: W] !== 8'h02) begin errors++; $display("FAIL dn_psc_wait: got %h expected %h", bus.cnt[1*W +: W], 8'h02); end
    tick(1);
    checks++; if (bus.cnt[1*W +: W] !== 8'h01) begin errors++; $display("FAIL dn_first_tick: got %h expected %h", bus.cnt[1*W +: W], 8'h01); end
    tick(4);
    checks++; if ({bus.cnt[1*W +: W], bus.ovf_flag[1], bus.done[1]} !== {8'h00, 2'b00}) begin errors++; $display("FAIL dn_reach_zero: got %h expected %h", {bus.cnt[1*W +: W], bus.ovf_flag[1], bus.done[1]}, {8'h00, 2'b00}); end
    tick(3);
    checks++; if ({bus.ovf_flag[1], bus.done[1]} !== 2'b00) begin errors++; $display("FAIL dn_pre_wrap: got %b expected 00", {bus.ovf_flag[1], bus.done[1]}); end
    tick(1);
    checks++; if ({bus.cnt[1*W +: W], bus.ovf_flag[1], bus.done[1]} !== {8'h00, 2'b11}) begin errors++; $display("FAIL dn_wrap: got %h expected %h", {bus.cnt[1*W +: W], bus.ovf_flag[1], bus.done[1]}, {8'h00, 2'b11}); end
    tick(4);
    checks++; if ({bus.cnt[1*W +: W], bus.done[1]} !== {8'h00, 1'b1}) begin errors++; $display("FAIL dn_done_hold: got %h expected %h", {bus.cnt[1*W +: W], bus.done[1]}, {8'h00, 1'b1}); end
    bus.tdr[1*W +: W] = 8'h05; bus.load[1] = 1'b1;
    tick(1);
    bus.load[1] = 1'b0;
    checks++; if ({bus.cnt[1*W +: W], bus.done[1]} !== {8'h05, 1'b0}) begin errors++; $display("FAIL dn_reload_run: got %h expected %h", {bus.cnt[1*W +: W], bus.done[1]}, {8'h05, 1'b0}); end
    tick(3);
    checks++; if ({bus.cnt[1*W +: W], bus.ovf_flag[1]} !== {8'h04, 1'b1}) begin errors++; $display("FAIL dn_resume: got %h expected %h", {bus.cnt[1*W +: W], bus.ovf_flag[1]}, {8'h04, 1'b1}); end
    bus.en[1] = 1'b0; bus.psc = 8'd0; bus.int_clr[1] = 1'b1;
    tick(1);
    bus.int_clr[1] = 1'b0;
    checks++; if (bus.ovf_flag[1] !== 1'b0) begin errors++; $display("FAIL dn_clr: got %b expected 0", bus.ovf_flag[1]); end
  endtask

  task automatic test_compare;
    bus.tdr[2*W +: W] = 8'h0E; bus.cmp[2*W +: W] = 8'h10;
    bus.updown[2] = 1'b0; bus.auto_reload[2] = 1'b1; bus.load[2] = 1'b1;
    tick(1);
    bus.load[2] = 1'b0; bus.en[2] = 1'b1;
    tick(1);
    checks++; if ({bus.cnt[2*W +: W], bus.cmp_flag[2]} !== {8'h0F, 1'b0}) begin errors++; $display("FAIL cmp_before: got %h expected %h", {bus.cnt[2*W +: W], bus.cmp_flag[2]}, {8'h0F, 1'b0}); end
    tick(1);
    checks++; if ({bus.cnt[2*W +: W], bus.cmp_flag[2], bus.irq} !== {8'h10, 2'b11}) begin errors++; $display("FAIL cmp_match: got %h expected %h", {bus.cnt[2*W +: W], bus.cmp_flag[2], bus.irq}, {8'h10, 2'b11}); end
    bus.en[2] = 1'b0; bus.int_clr[2] = 1'b1;
    tick(1);
    bus.int_clr[2] = 1'b0;
    checks++; if (bus.cmp_flag[2] !== 1'b0) begin errors++; $display("FAIL cmp_clr: got %b expected 0", bus.cmp_flag[2]); end
    bus.tdr[2*W +: W] = 8'h10; bus.load[2] = 1'b1;
    tick(1);
    bus.load[2] = 1'b0;
    checks++; if ({bus.cnt[2*W +: W], bus.cmp_flag[2]} !== {8'h10, 1'b0}) begin errors++; $display("FAIL cmp_load_no_flag: got %h expected %h", {bus.cnt[2*W +: W], bus.cmp_flag[2]}, {8'h10, 1'b0}); end
  endtask

  task automatic test_back_to_back;
    bus.tdr[3*W +: W] = 8'hFF; bus.cmp[3*W +: W] = 8'h77;
    bus.updown[3] = 1'b0; bus.auto_reload[3] = 1'b1; bus.load[3] = 1'b1;
    tick(1);
    bus.tdr[3*W +: W] = 8'h20; bus.en[3] = 1'b1;
    tick(1);
    bus.load[3] = 1'b0; bus.en[3] = 1'b0;
    checks++; if ({bus.cnt[3*W +: W], bus.ovf_flag[3]} !== {8'h20, 1'b0}) begin errors++; $display("FAIL prio_load_over_wrap: got %h expected %h", {bus.cnt[3*W +: W], bus.ovf_flag[3]}, {8'h20, 1'b0}); end
    bus.tdr[3*W +: W] = 8'hFF; bus.load[3] = 1'b1;
    tick(1);
    bus.load[3] = 1'b0; bus.en[3] = 1'b1; bus.int_clr[3] = 1'b1;
    tick(1);
    bus.en[3] = 1'b0;
    checks++; if ({bus.cnt[3*W +: W], bus.ovf_flag[3]} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL prio_set_over_clr: got %h expected %h", {bus.cnt[3*W +: W], bus.ovf_flag[3]}, {8'hFF, 1'b1}); end
    tick(1);
    bus.int_clr[3] = 1'b0;
    checks++; if (bus.ovf_flag[3] !== 1'b0) begin errors++; $display("FAIL prio_clr_after: got %b expected 0", bus.ovf_flag[3]); end
  endtask

  task automatic test_multichannel;
    logic [7:0] e [4];
    logic [7:0] prev [4];
    logic       ovf3;
    e = '{8'h10, 8'h10, 8'h10, 8'h01};
    ovf3 = 1'b0;
    bus.tdr = {8'h01, 8'h10, 8'h10, 8'h10};
    bus.cmp = {4{8'hC0}};
    bus.updown = 4'b1010; bus.auto_reload = 4'b0111; bus.load = 4'b1111;
    tick(1);
    bus.load = '0; bus.en = 4'b1011;
    checks++; if (bus.cnt !== {8'h01, 8'h10, 8'h10, 8'h10}) begin errors++; $display("FAIL mc_load: got %h expected %h", bus.cnt, {8'h01, 8'h10, 8'h10, 8'h10}); end
    for (int k = 1; k <= 3; k++) begin
      prev = e;
      e[0] = e[0] + 8'd1;
      e[1] = e[1] - 8'd1;
      if (e[3] != 8'h00) e[3] = e[3] - 8'd1;
      else ovf3 = 1'b1;
      tick(1);
      for (int i = 0; i < 4; i++) begin
        checks++; if (bus.cnt[i*W +: W] !== e[i]) begin errors++; $display("FAIL mc_cnt k%0d lane%0d: got %h expected %h", k, i, bus.cnt[i*W +: W], e[i]); end
        checks++; if (bus.last_cnt[i*W +: W] !== prev[i]) begin errors++; $display("FAIL mc_last k%0d lane%0d: got %h expected %h", k, i, bus.last_cnt[i*W +: W], prev[i]); end
      end
      checks++; if ({bus.ovf_flag, bus.done} !== {ovf3, 3'b000, ovf3, 3'b000}) begin errors++; $display("FAIL mc_flags k%0d: got %h expected %h", k, {bus.ovf_flag, bus.done}, {ovf3, 3'b000, ovf3, 3'b000}); end
    end
    bus.en = '0; bus.int_clr = 4'b1111;
    tick(1);
    bus.int_clr = '0;
  endtask

  task automatic test_async_reset;
    bus.tdr[0*W +: W] = 8'hFF; bus.updown[0] = 1'b0; bus.load[0] = 1'b1;
    tick(1);
    bus.load[0] = 1'b0; bus.en[0] = 1'b1;
    tick(1);
    checks++; if ({bus.ovf_flag[0], bus.irq, bus.done[3]} !== 3'b111) begin errors++; $display("FAIL ar_pre: got %b expected 111", {bus.ovf_flag[0], bus.irq, bus.done[3]}); end
    #2 preset_n = 1'b0;
    #1;
    checks++; if ({bus.cnt, bus.last_cnt} !== 64'h0) begin errors++; $display("FAIL ar_cnt_async: got %h expected %h", {bus.cnt, bus.last_cnt}, 64'h0); end
    checks++; if ({bus.ovf_flag, bus.cmp_flag, bus.done, bus.irq} !== 13'h0) begin errors++; $display("FAIL ar_flags_async: got %h expected %h", {bus.ovf_flag, bus.cmp_flag, bus.done, bus.irq}, 13'h0); end
    bus.en = '0; bus.load = '0;
    tick(1);
    preset_n = 1'b1;
    tick(3);
    checks++; if (bus.cnt !== 32'h0) begin errors++; $display("FAIL ar_idle: got %h expected %h", bus.cnt, 32'h0); end
    bus.tdr[1*W +: W] = 8'h33; bus.updown[1] = 1'b1; bus.auto_reload[1] = 1'b1; bus.en[1] = 1'b1;
    tick(1);
    bus.en[1] = 1'b0;
    checks++; if ({bus.cnt[1*W +: W], bus.ovf_flag[1]} !== {8'h33, 1'b1}) begin errors++; $display("FAIL ar_down_from_zero: got %h expected %h", {bus.cnt[1*W +: W], bus.ovf_flag[1]}, {8'h33, 1'b1}); end
  endtask

  initial begin
    test_reset;
    test_up_periodic;
    test_down_oneshot;
    test_compare;
    test_back_to_back;
    test_multichannel;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter_mc.md
# timer_counter_mc

Multi-channel, parametrised timer counter for the APB timer peripheral: NCH independent counters of WIDTH bits share one programmable prescaler. Each channel counts up or down, runs one-shot or periodic-reload, and raises sticky wrap and compare flags. The flags are ORed into a single interrupt request for the interrupt handler. This block replaces the single-channel, un-prescaled counter inside the timer.

## Interface
- WIDTH, 32, counter width per channel (2..32)
- NCH, 4, number of channels (1..8)
- PSC_W, 8, prescaler divisor width
- pclk  in  1  clock; all logic on rising edge
- preset_n  in  1  asynchronous active-low reset
- psc  in  PSC_W  prescaler divisor; a tick occurs every psc+1 pclk cycles
- load  in  NCH  per-channel load of tdr into cnt
- en  in  NCH  per-channel count enable
- updown  in  NCH  1 = count down, 0 = count up
- auto_reload  in  NCH  1 = periodic (reload on wrap), 0 = one-shot
- int_clr  in  NCH  clear ovf_flag and cmp_flag of the channel
- tdr  in  NCH*WIDTH  reload values; channel i occupies [i*WIDTH +: WIDTH]
- cmp  in  NCH*WIDTH  compare values, packed the same way
- cnt  out  NCH*WIDTH  current counts
- last_cnt  out  NCH*WIDTH  cnt delayed by one pclk
- ovf_flag  out  NCH  sticky wrap (overflow/underflow) flag
- cmp_flag  out  NCH  sticky compare-match flag
- done  out  NCH  channel is in the DONE state
- irq  out  1  |(ovf_flag | cmp_flag)

## Operation
- Prescaler: psc_cnt (PSC_W bits), reset value 0, free-running.
  - If psc_cnt >= psc: tick = 1 and psc_cnt <= 0. Otherwise psc_cnt increments.
  - psc = 0 gives a tick every cycle. Lowering psc below psc_cnt produces a tick on the next cycle.
- Channel i has a 2-state FSM: RUN (reset state) and DONE.
  - RUN → DONE on a wrap event with auto_reload[i] = 0.
  - DONE → RUN on load[i]. No other exit from DONE.
- Terminal value is all-ones when counting up and 0 when counting down.
- Channel update priority, evaluated each cycle:
  1. load[i]: cnt <= tdr and state <= RUN. No flags are set, even if tdr equals cmp or the terminal value.
  2. en[i] & tick & RUN & cnt == terminal (wrap event): set ovf_flag.
     - auto_reload = 1: cnt <= tdr.
     - auto_reload = 0: cnt holds at the terminal value and state <= DONE.
  3. en[i] & tick & RUN (no wrap): cnt <= cnt ± 1, modulo 2^WIDTH.
  4. Otherwise cnt holds. In DONE, cnt holds and no flags are set regardless of en or tick.
- Compare: cmp_flag is set when a rule-2 or rule-3 update writes a next value equal to cmp[i]. A value written by load never sets cmp_flag.
- Flags are sticky until int_clr[i]. If set and clear occur in the same cycle, set wins.
- updown and auto_reload are sampled at each tick. Changing them mid-count affects only the next update.
- last_cnt <= cnt every cycle, unconditionally.
- Channels are fully independent except for the shared tick.

## Timing
- Reset values: cnt = 0, last_cnt = 0, ovf_flag = 0, cmp_flag = 0, done = 0, irq = 0, psc_cnt = 0, state = RUN.
- Reset is asynchronous: asserting it mid-count clears all state immediately. The first tick after release comes psc+1 cycles after the first rising edge with preset_n high.
- load asserted at edge N: cnt = tdr after edge N. last_cnt = tdr after edge N+1.
- Count latency: one edge after a cycle with en & tick.
- Flags and done update on the same edge as the causing cnt update. irq is combinational from the flag registers, so it asserts in that same cycle.
- A down-counting channel left at reset (cnt = 0) wraps on its first enabled tick.
- All outputs are registered except irq.

## Test plan
- WIDTH=8, psc=0, up, periodic, tdr=0xFC, load then en: cnt goes FC, FD, FE, FF, FC. ovf_flag rises with the return to 0xFC. irq = 1. int_clr clears both.
- WIDTH=8, psc=3, down, one-shot, tdr=2, load then en: cnt steps every 4 cycles 2, 1, 0, then holds 0. ovf_flag and done set on the wrap tick. A later load with tdr=5 clears done and resumes counting from 5.
- cmp=0x10, up, tdr=0x0E: cmp_flag sets on the edge where cnt becomes 0x10. A separate load with tdr=0x10 leaves cmp_flag at 0.
- Simultaneous load and wrap tick on the same channel: cnt = tdr, ovf_flag unchanged (load priority). Simultaneous int_clr and flag set: flag stays 1.
- NCH=4, channels 0/1/2/3 configured with different modes and en masks: each channel follows its own rules. Disabled channels hold cnt. last_cnt equals the previous-cycle cnt on every lane.
- preset_n pulsed low mid-count with flags set: all outputs return to 0 asynchronously. After release, counting restarts only after load/en and the first tick.
